// File: rtl/rc_envelope_vca.sv
// Attack/hold/release envelope generator driving a VCA on a 16-bit signed audio stream.
// All state advances only on the audio sample strobe; reset overrides everything.
module rc_envelope_vca #(
    parameter int ATTACK_SHIFT  = 4,
    parameter int RELEASE_SHIFT = 8,
    parameter int ENV_MAX       = 32767
) (
    input  logic               clk,
    input  logic               I_RST,
    input  logic               audio_clk_en,
    input  logic               gate,
    input  logic signed [15:0] in,
    output logic signed [15:0] out,
    output logic [15:0]        env,
    output logic               busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ATTACK  = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam logic [15:0] ENV_MAX_W = 16'(ENV_MAX);

    logic [1:0]         state_q, state_d;
    logic [15:0]        env_q, env_d;
    logic signed [15:0] out_q, out_d;
    logic               busy_q, busy_d;

    // Exponential approach to full scale; the +1 guarantees ENV_MAX is reached.
    function automatic logic [15:0] attack_step(input logic [15:0] e);
        logic [16:0] gap;
        logic [16:0] nxt;
        gap = (e >= ENV_MAX_W) ? 17'd0 : {1'b0, ENV_MAX_W - e};
        nxt = {1'b0, e} + (gap >> ATTACK_SHIFT) + 17'd1;
        return (nxt >= {1'b0, ENV_MAX_W}) ? ENV_MAX_W : nxt[15:0];
    endfunction

    function automatic logic [15:0] release_step(input logic [15:0] e);
        logic [15:0] dec;
        dec = (e >> RELEASE_SHIFT) + 16'd1;
        return (e <= dec) ? 16'd0 : e - dec;
    endfunction

    // Signed sample times unsigned gain, floored back to Q15.
    function automatic logic signed [15:0] scale(input logic signed [15:0] x,
                                                 input logic [15:0]        e);
        logic signed [32:0] p;
        p = $signed({{17{x[15]}}, x}) * $signed({17'd0, e});
        return 16'(p >>> 15);
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (gate) state_d = S_ATTACK;
            S_ATTACK:  if (!gate) state_d = S_RELEASE;
                       else if (env_q == ENV_MAX_W) state_d = S_HOLD;
            S_HOLD:    if (!gate) state_d = S_RELEASE;
            S_RELEASE: if (gate) state_d = S_ATTACK;
                       else if (env_q == 16'd0) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        env_d = env_q;
        case (state_d)
            S_ATTACK:  env_d = attack_step(env_q);
            S_RELEASE: env_d = release_step(env_q);
            default:   env_d = env_q;
        endcase

        // Gain uses the envelope as it was before this sample's update.
        out_d  = scale(in, env_q);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (I_RST) begin
            state_q <= S_IDLE;
            env_q   <= 16'd0;
            out_q   <= 16'sd0;
            busy_q  <= 1'b0;
        end else if (audio_clk_en) begin
            state_q <= state_d;
            env_q   <= env_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
        end
    end

    assign out  = out_q;
    assign env  = env_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_rc_envelope_vca.sv
// Scoreboard bench for rc_envelope_vca: stimulus pushes predictions from an arithmetic
// envelope model, a monitor pops and compares after every clock edge.
module tb_rc_envelope_vca;

    localparam int AS   = 4;
    localparam int RS   = 8;
    localparam int EMAX = 32767;

    localparam int M_IDLE = 0, M_ATTACK = 1, M_HOLD = 2, M_RELEASE = 3;

    logic               clk = 1'b0;
    logic               I_RST = 1'b1;
    logic               audio_clk_en = 1'b0;
    logic               gate = 1'b0;
    logic signed [15:0] in = 16'sd0;
    logic signed [15:0] out;
    logic [15:0]        env;
    logic               busy;

    always #5 clk = ~clk;

    rc_envelope_vca #(
        .ATTACK_SHIFT (AS),
        .RELEASE_SHIFT(RS),
        .ENV_MAX      (EMAX)
    ) dut (
        .clk         (clk),
        .I_RST       (I_RST),
        .audio_clk_en(audio_clk_en),
        .gate        (gate),
        .in          (in),
        .out         (out),
        .env         (env),
        .busy        (busy)
    );

    typedef struct {
        int out_v;
        int env_v;
        bit busy_v;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int m_state = M_IDLE;
    int m_env   = 0;
    int m_out   = 0;
    bit m_busy  = 1'b0;

    function automatic int floor_q15(longint p);
        if (p >= 0) return int'(p / 32768);
        return -int'((-p + 32767) / 32768);
    endfunction

    // Reference model: advance one clock edge with the given inputs.
    task automatic model_edge(bit rst, bit en, bit g, int xs);
        int nxt;
        if (rst) begin
            m_state = M_IDLE; m_env = 0; m_out = 0; m_busy = 1'b0;
        end else if (en) begin
            nxt = m_state;
            case (m_state)
                M_IDLE:    if (g) nxt = M_ATTACK;
                M_ATTACK:  if (!g) nxt = M_RELEASE; else if (m_env == EMAX) nxt = M_HOLD;
                M_HOLD:    if (!g) nxt = M_RELEASE;
                default:   if (g) nxt = M_ATTACK; else if (m_env == 0) nxt = M_IDLE;
            endcase
            m_out = floor_q15(longint'(xs) * longint'(m_env));
            if (nxt == M_ATTACK) begin
                m_env = m_env + (EMAX - m_env) / (2 ** AS) + 1;
                if (m_env > EMAX) m_env = EMAX;
            end else if (nxt == M_RELEASE) begin
                m_env = m_env - m_env / (2 ** RS) - 1;
                if (m_env < 0) m_env = 0;
            end
            m_state = nxt;
            m_busy  = (nxt != M_IDLE);
        end
    endtask

    task automatic step(bit rst, bit en, bit g, int x);
        logic signed [15:0] x16;
        exp_t e;
        x16 = x[15:0];
        @(negedge clk);
        I_RST = rst; audio_clk_en = en; gate = g; in = x16;
        model_edge(rst, en, g, int'(x16));
        e.out_v = m_out; e.env_v = m_env; e.busy_v = m_busy;
        sbq.push_back(e);
    endtask

    task automatic dcheck(string name, int act, int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every edge that has a pending prediction is checked.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_tests++;
            if (int'(out) !== e.out_v || int'(env) !== e.env_v || busy !== e.busy_v) begin
                n_fail++;
                $display("FAIL sb_edge: got out=%0d env=%0d busy=%0b, required out=%0d env=%0d busy=%0b",
                         out, env, busy, e.out_v, e.env_v, e.busy_v);
            end
        end
    end

    initial begin
        int e_mid;
        int e_req;

        repeat (3) step(1, 1, 1, 16384);
        repeat (10) step(0, 1, 0, 16384);

        step(0, 1, 1, 16384);
        settle();
        dcheck("first_attack_env", int'(env), 2048);
        dcheck("first_attack_busy", int'(busy), 1);
        dcheck("first_attack_out", int'(out), 0);
        step(0, 1, 1, 16384);
        settle();
        dcheck("second_attack_out", int'(out), 1024);

        for (int i = 0; i < 600 && m_state != M_HOLD; i++) begin
            step(0, 1, 1, int'($urandom));
            if ($urandom_range(3) == 0) step(0, 0, 1'($urandom_range(1)), int'($urandom));
        end
        dcheck("reached_hold", m_state, M_HOLD);

        repeat (2) step(0, 1, 1, 16384);
        settle();
        dcheck("hold_out_pos", int'(out), 16383);
        step(0, 1, 1, -16384);
        settle();
        dcheck("hold_out_neg", int'(out), -16384);

        step(0, 1, 0, 16384);
        settle();
        dcheck("first_release_env", int'(env), 32639);
        dcheck("first_release_busy", int'(busy), 1);

        for (int i = 0; i < 4000 && m_state != M_IDLE; i++) begin
            step(0, 1, 0, int'($urandom));
            if ($urandom_range(7) == 0) step(0, 0, 1'($urandom_range(1)), int'($urandom));
        end
        settle();
        dcheck("release_idle_busy", int'(busy), 0);
        dcheck("release_idle_env", int'(env), 0);

        repeat (40) step(0, 1, 1, int'($urandom));
        repeat (150) step(0, 1, 0, int'($urandom));
        e_mid = m_env;
        e_req = e_mid + ((32767 - e_mid) >> 4) + 1;
        step(0, 1, 1, 12345);
        settle();
        dcheck("retrigger_env", int'(env), e_req);
        dcheck("retrigger_busy", int'(busy), 1);

        step(1, 1, 1, 20000);
        settle();
        dcheck("reset_mid_attack_env", int'(env), 0);
        dcheck("reset_mid_attack_out", int'(out), 0);
        dcheck("reset_mid_attack_busy", int'(busy), 0);

        for (int i = 0; i < 6; i++) step(0, 0, 1'(i % 2), int'($urandom));
        step(0, 1, 1, 16384);
        settle();
        dcheck("post_reset_attack_env", int'(env), 2048);

        for (int i = 0; i < 3000; i++) begin
            bit g;
            g = gate;
            if ($urandom_range(299) == 0) g = ~g;
            step($urandom_range(199) == 0, $urandom_range(2) != 0, g, int'($urandom));
        end

        @(negedge clk);
        audio_clk_en = 1'b0;
        repeat (3) @(negedge clk);
        dcheck("scoreboard_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
